// File: rtl/aes256_pkg.sv
// Shared definitions for the AES-256 CTR coprocessor: sequencer state
// encoding, default timing constants and the coprocessor register map.
package aes256_pkg;

    // Job sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LDKEY   = 3'd1,
        ST_LDNONCE = 3'd2,
        ST_WAITIN  = 3'd3,
        ST_RUN     = 3'd4,
        ST_GAP     = 3'd5,
        ST_DRAIN   = 3'd6,
        ST_DONE    = 3'd7
    } seq_state_t;

    // Minimum cycles between run pulses (AES engine latency).
    localparam int AES_LAT_DEF   = 14;
    // Drain cycles allowed before the output FIFO is declared stuck.
    localparam int DRAIN_MAX_DEF = 64;

    // Coprocessor register map (byte addresses) used by aes256_coprocessor.
    localparam logic [7:0] REG_CTRL        = 8'h00;
    localparam logic [7:0] REG_STATUS      = 8'h04;
    localparam logic [7:0] REG_JOB_BLOCKS  = 8'h08;
    localparam logic [7:0] REG_BLOCKS_DONE = 8'h0C;
    localparam logic [7:0] REG_IRQ         = 8'h10;
    localparam logic [7:0] REG_KEY_BASE    = 8'h20;
    localparam logic [7:0] REG_NONCE_BASE  = 8'h40;

    // Counter width able to hold the larger of two load values.
    function automatic int pacer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/aes_seq_pacer.sv
// Loadable down-counter used by the sequencer to time the post-run gap and
// the output drain. zero_next flags that the decrement happening this cycle
// lands the count on zero, so the caller can leave its waiting state on the
// same edge the counter empties.
module aes_seq_pacer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero_next
);

    logic [W-1:0] count_q;

    // Count register: load has priority over decrement; count floors at zero.
    // NOTE: clocked state is written with <= so every flop samples the
    // pre-edge values; a blocking = here would chain updates within one edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_next = (count_q <= W'(1));

endmodule

// File: rtl/aes256_ctr_sequencer.sv
// Job-level controller for the AES-256 CTR datapath. Loads key and nonce,
// issues one run pulse per available input block paced by the AES latency
// and output back-pressure, drains the output FIFO, then raises done_irq.
module aes256_ctr_sequencer
    import aes256_pkg::*;
#(
    parameter int CNTW      = 16,
    parameter int AES_LAT   = AES_LAT_DEF,
    parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic            key_dirty,
    input  logic [CNTW-1:0] job_blocks,
    input  logic            ibf_empty,
    input  logic            obf_full,
    input  logic            obf_empty,
    output logic            setkey,
    output logic            setnonce,
    output logic            run,
    output logic            dp_reset,
    output logic            key_loaded,
    output logic            busy,
    output logic            done_irq,
    output logic            err,
    output logic [CNTW-1:0] blocks_done
);

    localparam int PW = pacer_width(AES_LAT, DRAIN_MAX);

    seq_state_t      state_q;
    seq_state_t      state_d;
    logic [CNTW-1:0] target_q;
    logic [CNTW-1:0] blocks_done_q;
    logic            done_irq_q;
    logic            err_q;
    logic            dp_reset_q;

    logic            launch;
    logic            timeout;
    logic            enter_done;
    logic            gap_load;
    logic            gap_dec;
    logic            gap_last;
    logic            drain_load;
    logic            drain_dec;
    logic            drain_last;

    // Post-run spacing: loaded in RUN, counts down through GAP.
    aes_seq_pacer #(.W(PW)) u_gap_pacer (
        .clock      (clock),
        .reset      (reset),
        .load       (gap_load),
        .load_value (PW'(AES_LAT - 1)),
        .dec        (gap_dec),
        .zero_next  (gap_last)
    );

    // Drain timeout: loaded on entry to DRAIN, counts down each DRAIN cycle.
    aes_seq_pacer #(.W(PW)) u_drain_pacer (
        .clock      (clock),
        .reset      (reset),
        .load       (drain_load),
        .load_value (PW'(DRAIN_MAX)),
        .dec        (drain_dec),
        .zero_next  (drain_last)
    );

    // Next-state and pacer control; abort overrides every normal transition.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        launch     = 1'b0;
        timeout    = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;
        drain_load = 1'b0;
        drain_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    launch  = 1'b1;
                    state_d = key_dirty ? ST_LDKEY : ST_LDNONCE;
                end
            end
            ST_LDKEY: begin
                state_d = ST_LDNONCE;
            end
            ST_LDNONCE: begin
                state_d = (target_q == '0) ? ST_DONE : ST_WAITIN;
            end
            ST_WAITIN: begin
                if (blocks_done_q == target_q) begin
                    state_d    = ST_DRAIN;
                    drain_load = 1'b1;
                end else if (!ibf_empty && !obf_full) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                gap_load = 1'b1;
                state_d  = ST_GAP;
            end
            ST_GAP: begin
                gap_dec = 1'b1;
                if (gap_last) begin
                    state_d = ST_WAITIN;
                end
            end
            ST_DRAIN: begin
                drain_dec = 1'b1;
                if (obf_empty) begin
                    state_d = ST_DONE;
                end else if (drain_last) begin
                    timeout = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            launch     = 1'b0;
            timeout    = 1'b0;
            gap_load   = 1'b0;
            drain_load = 1'b0;
        end
    end

    assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job bookkeeping: target latch, progress count, interrupt, error, abort pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            target_q      <= '0;
            blocks_done_q <= '0;
            done_irq_q    <= 1'b0;
            err_q         <= 1'b0;
            dp_reset_q    <= 1'b0;
        end else begin
            dp_reset_q <= abort;

            if (launch) begin
                target_q      <= job_blocks;
                blocks_done_q <= '0;
                err_q         <= 1'b0;
            end else begin
                // A run already on the wire is counted even if abort arrives with it.
                if ((state_q == ST_RUN) && (blocks_done_q != target_q)) begin
                    blocks_done_q <= blocks_done_q + CNTW'(1);
                end
                if (timeout) begin
                    err_q <= 1'b1;
                end
            end

            if (abort || launch) begin
                done_irq_q <= 1'b0;
            end else if (enter_done) begin
                done_irq_q <= 1'b1;
            end
        end
    end

    // Control pulses are decoded straight from the state, so at most one is high.
    assign setkey      = (state_q == ST_LDKEY);
    assign key_loaded  = (state_q == ST_LDKEY);
    assign setnonce    = (state_q == ST_LDNONCE);
    assign run         = (state_q == ST_RUN);
    assign busy        = (state_q != ST_IDLE);
    assign dp_reset    = dp_reset_q;
    assign done_irq    = done_irq_q;
    assign err         = err_q;
    assign blocks_done = blocks_done_q;

endmodule

// File: tb/tb_aes256_ctr_sequencer.sv
// Self-checking bench for aes256_ctr_sequencer: a timestamp-based job model
// predicts every output each cycle; directed scenarios pin the model with
// hand-computed cycle offsets; a randomized phase exercises the rest.
module tb_aes256_ctr_sequencer;

    localparam int CNTW      = 16;
    localparam int AES_LAT   = 14;
    localparam int DRAIN_MAX = 64;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            key_dirty = 1'b0;
    logic [CNTW-1:0] job_blocks = '0;
    logic            ibf_empty = 1'b1;
    logic            obf_full = 1'b0;
    logic            obf_empty = 1'b1;
    logic            setkey, setnonce, run, dp_reset, key_loaded, busy, done_irq, err;
    logic [CNTW-1:0] blocks_done;

    aes256_ctr_sequencer #(
        .CNTW      (CNTW),
        .AES_LAT   (AES_LAT),
        .DRAIN_MAX (DRAIN_MAX)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .key_dirty   (key_dirty),
        .job_blocks  (job_blocks),
        .ibf_empty   (ibf_empty),
        .obf_full    (obf_full),
        .obf_empty   (obf_empty),
        .setkey      (setkey),
        .setnonce    (setnonce),
        .run         (run),
        .dp_reset    (dp_reset),
        .key_loaded  (key_loaded),
        .busy        (busy),
        .done_irq    (done_irq),
        .err         (err),
        .blocks_done (blocks_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- behavioural job model ----------------
    // A job is described by the cycle numbers at which its events happen.
    int cyc = 0;
    bit m_busy, m_done, m_err, m_dp;
    int m_target, m_cnt;
    int m_key_at, m_nonce_at, m_run_at, m_wait_from, m_drain_from, m_done_at;

    task automatic model_clear();
        m_busy = 0; m_done = 0; m_err = 0; m_dp = 0;
        m_target = 0; m_cnt = 0;
        m_key_at = -1; m_nonce_at = -1; m_run_at = -1;
        m_wait_from = -1; m_drain_from = -1; m_done_at = -1;
    endtask

    // Inputs seen during cycle c decide the outputs of cycle c+1.
    task automatic model_step(input int c);
        if (c == m_run_at) m_cnt++;
        m_dp = abort;
        if (abort) begin
            m_busy = 0; m_done = 0;
            m_key_at = -1; m_nonce_at = -1; m_run_at = -1;
            m_wait_from = -1; m_drain_from = -1; m_done_at = -1;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_target = int'(job_blocks); m_cnt = 0; m_done = 0; m_err = 0;
                m_key_at   = key_dirty ? c + 1 : -1;
                m_nonce_at = c + 1 + (key_dirty ? 1 : 0);
                m_run_at = -1; m_drain_from = -1; m_wait_from = -1; m_done_at = -1;
                if (m_target == 0) m_done_at = m_nonce_at + 1;
                else               m_wait_from = m_nonce_at + 1;
            end
        end else if (c == m_done_at) begin
            m_busy = 0;
            m_done_at = -1;
        end else if (m_wait_from >= 0 && c >= m_wait_from) begin
            if (m_cnt == m_target) begin
                m_drain_from = c + 1;
                m_wait_from = -1;
            end else if (!ibf_empty && !obf_full) begin
                m_run_at = c + 1;
                m_wait_from = c + 1 + AES_LAT;
            end
        end else if (m_drain_from >= 0 && c >= m_drain_from) begin
            if (obf_empty) begin
                m_done_at = c + 1;
                m_drain_from = -1;
            end else if (c - m_drain_from + 1 == DRAIN_MAX) begin
                m_err = 1;
                m_done_at = c + 1;
                m_drain_from = -1;
            end
        end
        if (m_busy && (c + 1 == m_done_at)) m_done = 1;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_clear();
        end else begin
            model_step(cyc);
            cyc++;
        end
    end

    // Compare every DUT output against the model on the falling edge.
    bit cmp_en = 0;
    always @(negedge clock) begin
        if (cmp_en && !reset) begin
            check("setkey",      32'(setkey),      32'(cyc == m_key_at));
            check("key_loaded",  32'(key_loaded),  32'(cyc == m_key_at));
            check("setnonce",    32'(setnonce),    32'(cyc == m_nonce_at));
            check("run",         32'(run),         32'(cyc == m_run_at));
            check("dp_reset",    32'(dp_reset),    32'(m_dp));
            check("busy",        32'(busy),        32'(m_busy));
            check("done_irq",    32'(done_irq),    32'(m_done));
            check("err",         32'(err),         32'(m_err));
            check("blocks_done", 32'(blocks_done), 32'(m_cnt));
            check("ctrl_exclusive", 32'((int'(setkey) + int'(setnonce) + int'(run)) <= 1), 32'd1);
        end
    end

    // Event log used by the directed scenarios.
    int   run_log[$];
    int   key_log[$];
    int   nonce_log[$];
    int   done_log[$];
    int   err_log[$];
    logic done_prev = 1'b0;
    logic err_prev  = 1'b0;
    always @(negedge clock) begin
        if (!reset) begin
            if (run)                   run_log.push_back(cyc);
            if (setkey)                key_log.push_back(cyc);
            if (setnonce)              nonce_log.push_back(cyc);
            if (done_irq && !done_prev) done_log.push_back(cyc);
            if (err && !err_prev)       err_log.push_back(cyc);
        end
        done_prev <= done_irq;
        err_prev  <= err;
    end

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #2;
    endtask

    task automatic pulse_start(input bit kd, input int blocks, output int s);
        key_dirty  = kd;
        job_blocks = CNTW'(blocks);
        s = cyc;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        key_dirty = 1'b0;
    endtask

    task automatic wait_runs(input int total, input int budget);
        int n = 0;
        while (run_log.size() < total && n < budget) begin
            next_cycle();
            n++;
        end
        check("runs_reached", 32'(run_log.size()), 32'(total));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            next_cycle();
            n++;
        end
        check("job_finished", 32'(busy), 32'd0);
    endtask

    initial begin
        int s, h, a, rb, kb, nb, db, eb;
        int empty_bias;

        #1 reset = 1'b1;
        #3;
        check("rst_setkey",      32'(setkey),      32'd0);
        check("rst_setnonce",    32'(setnonce),    32'd0);
        check("rst_run",         32'(run),         32'd0);
        check("rst_dp_reset",    32'(dp_reset),    32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_done_irq",    32'(done_irq),    32'd0);
        check("rst_err",         32'(err),         32'd0);
        check("rst_blocks_done", 32'(blocks_done), 32'd0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        cmp_en = 1;
        next_cycle();

        // Nominal job with key load.
        ibf_empty = 0; obf_full = 0; obf_empty = 0;
        rb = run_log.size(); kb = key_log.size(); nb = nonce_log.size();
        pulse_start(1'b1, 3, s);
        wait_runs(rb + 3, 200);
        check("nom_setkey_at",   32'(q_at(key_log, kb) - s),   32'd1);
        check("nom_setnonce_at", 32'(q_at(nonce_log, nb) - s), 32'd2);
        check("nom_run0_at",     32'(q_at(run_log, rb) - s),   32'd4);
        check("nom_run_gap1",    32'(q_at(run_log, rb + 1) - q_at(run_log, rb)),     32'd15);
        check("nom_run_gap2",    32'(q_at(run_log, rb + 2) - q_at(run_log, rb + 1)), 32'd15);
        obf_empty = 1;
        wait_idle(100);
        next_cycle();
        check("nom_blocks_done", 32'(blocks_done), 32'd3);
        check("nom_done_irq",    32'(done_irq),    32'd1);
        check("nom_busy",        32'(busy),        32'd0);

        // Key reuse, zero-length job.
        rb = run_log.size(); kb = key_log.size(); nb = nonce_log.size(); db = done_log.size();
        pulse_start(1'b0, 0, s);
        repeat (5) next_cycle();
        check("zero_no_setkey",   32'(key_log.size() - kb),     32'd0);
        check("zero_one_nonce",   32'(nonce_log.size() - nb),   32'd1);
        check("zero_nonce_at",    32'(q_at(nonce_log, nb) - s), 32'd1);
        check("zero_done_at",     32'(q_at(done_log, db) - s),  32'd2);
        check("zero_no_run",      32'(run_log.size() - rb),     32'd0);

        // Output back-pressure after the second run.
        obf_empty = 0;
        rb = run_log.size();
        pulse_start(1'b0, 4, s);
        wait_runs(rb + 2, 100);
        obf_full = 1;
        repeat (40) next_cycle();
        check("bp_runs_in_hold", 32'(run_log.size() - rb), 32'd2);
        h = cyc;
        obf_full = 0;
        wait_runs(rb + 3, 10);
        check("bp_run3_latency", 32'(q_at(run_log, rb + 2) - h), 32'd1);
        wait_runs(rb + 4, 40);
        obf_empty = 1;
        wait_idle(100);
        check("bp_blocks_done", 32'(blocks_done), 32'd4);

        // Input starvation.
        ibf_empty = 1;
        rb = run_log.size();
        pulse_start(1'b0, 2, s);
        repeat (100) next_cycle();
        check("starve_no_run", 32'(run_log.size() - rb), 32'd0);
        check("starve_busy",   32'(busy), 32'd1);
        h = cyc;
        ibf_empty = 0;
        wait_runs(rb + 1, 5);
        check("starve_run_latency", 32'(q_at(run_log, rb) - h), 32'd1);
        wait_idle(200);

        // Abort during GAP, with a start in the same cycle.
        rb = run_log.size(); nb = nonce_log.size();
        pulse_start(1'b0, 5, s);
        wait_runs(rb + 2, 100);
        repeat (2) next_cycle();
        a = cyc;
        abort = 1; start = 1; job_blocks = CNTW'(9);
        next_cycle();
        abort = 0; start = 0;
        check("abort_dp_reset",    32'(dp_reset),    32'd1);
        check("abort_busy",        32'(busy),        32'd0);
        check("abort_blocks_done", 32'(blocks_done), 32'd2);
        check("abort_done_irq",    32'(done_irq),    32'd0);
        next_cycle();
        check("abort_dp_one_cycle", 32'(dp_reset), 32'd0);
        repeat (20) next_cycle();
        check("abort_start_ignored", 32'(busy), 32'd0);
        check("abort_no_more_runs",  32'(run_log.size() - rb), 32'd2);
        check("abort_no_new_nonce",  32'(nonce_log.size() - nb), 32'd1);

        // Drain timeout, then start clears err.
        obf_empty = 0;
        eb = err_log.size(); db = done_log.size();
        pulse_start(1'b0, 1, s);
        wait_idle(200);
        check("drain_err_at",  32'(q_at(err_log, eb) - s),  32'd82);
        check("drain_done_at", 32'(q_at(done_log, db) - s), 32'd82);
        check("drain_err_set", 32'(err), 32'd1);
        obf_empty = 1;
        pulse_start(1'b0, 0, s);
        check("drain_err_cleared", 32'(err), 32'd0);
        wait_idle(20);

        // Asynchronous reset mid-job.
        rb = run_log.size();
        pulse_start(1'b1, 3, s);
        wait_runs(rb + 1, 50);
        #1 reset = 1'b1;
        #1;
        check("areset_busy",        32'(busy),        32'd0);
        check("areset_run",         32'(run),         32'd0);
        check("areset_dp_reset",    32'(dp_reset),    32'd0);
        check("areset_done_irq",    32'(done_irq),    32'd0);
        check("areset_blocks_done", 32'(blocks_done), 32'd0);
        @(posedge clock);
        #2 reset = 1'b0;
        next_cycle();

        // Randomized traffic checked cycle by cycle against the model.
        empty_bias = 1;
        for (int i = 0; i < 6000; i++) begin
            if (i % 600 == 0) empty_bias = $urandom_range(0, 2);
            ibf_empty  = ($urandom_range(0, 3) == 0);
            obf_full   = ($urandom_range(0, 4) == 0);
            obf_empty  = (empty_bias == 0) ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 2) != 0);
            key_dirty  = $urandom_range(0, 1);
            job_blocks = CNTW'($urandom_range(0, 4));
            start      = ($urandom_range(0, 15) == 0);
            abort      = ($urandom_range(0, 399) == 0);
            next_cycle();
        end
        start = 0; abort = 0;
        repeat (3) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
